// File: rtl/egress_arbiter.sv
// egress_arbiter: frame-granular round-robin sharing of one egress port among NUM_INGRESS tagged filter streams.
// Latency: grant is registered one cycle after a request is seen in IDLE; the data path is a zero-latency mux.
// Backpressure: egress tready goes only to the owning filter while BUSY; all other filters always see tready=0.

package egress_arbiter_pkg;

    // Tagged stream presented by each ingress filter.
    typedef struct packed {
        logic        tvalid;
        logic [15:0] tdata;
        logic [1:0]  tdest;
        logic        tlast;
    } axis_d_source_t;

    typedef struct packed {
        logic tready;
    } axis_d_sink_t;

    // Untagged stream delivered to the egress port.
    typedef struct packed {
        logic        tvalid;
        logic [15:0] tdata;
        logic        tlast;
    } axis_source_t;

    typedef struct packed {
        logic tready;
    } axis_sink_t;

endpackage

module egress_arbiter
    import egress_arbiter_pkg::*;
#(
    parameter int         NUM_INGRESS       = 4,
    parameter logic [1:0] EGRESS_ID         = 2'd0,
    parameter int         TIMEOUT_CTR_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  axis_d_source_t         filter_source [NUM_INGRESS],
    output axis_d_sink_t           filter_sink   [NUM_INGRESS],
    output axis_source_t           egress_source,
    input  axis_sink_t             egress_sink,
    output logic [NUM_INGRESS-1:0] grant,
    output logic [15:0]            frame_count,
    output logic                   abort
);

    localparam int IDX_W = (NUM_INGRESS > 1) ? $clog2(NUM_INGRESS) : 1;

    // Stall limit is the all-ones value of the stall counter.
    localparam logic [TIMEOUT_CTR_WIDTH-1:0] STALL_LIMIT = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [NUM_INGRESS-1:0]       grant_nxt;
    logic [IDX_W-1:0]             owner;
    logic [IDX_W-1:0]             owner_nxt;
    logic [IDX_W-1:0]             last_grant;
    logic [IDX_W-1:0]             last_grant_nxt;
    logic [TIMEOUT_CTR_WIDTH-1:0] stall_cnt;
    logic [TIMEOUT_CTR_WIDTH-1:0] stall_cnt_nxt;
    logic [15:0]                  frame_count_nxt;
    logic                         abort_nxt;

    logic [NUM_INGRESS-1:0]       req;
    logic                         pick_vld;
    logic [IDX_W-1:0]             pick_idx;
    logic [IDX_W-1:0]             rr_cand;

    // Owner's stream, selected by the encoded owner index kept next to the one-hot grant.
    logic                         own_vld;
    logic [15:0]                  own_dat;
    logic                         own_last;
    logic                         beat_xfer;

    assign own_vld   = filter_source[owner].tvalid;
    assign own_dat   = filter_source[owner].tdata;
    assign own_last  = filter_source[owner].tlast;
    assign beat_xfer = own_vld && egress_sink.tready;

    // A filter requests only when its head beat is valid and tagged for this egress port.
    always_comb begin
        for (int i = 0; i < NUM_INGRESS; i++) begin
            req[i] = filter_source[i].tvalid && (filter_source[i].tdest == EGRESS_ID);
        end
    end

    // Round-robin pick: first requester scanning upward from the slot after the previous owner.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        rr_cand  = '0;
        for (int k = 1; k <= NUM_INGRESS; k++) begin
            rr_cand = IDX_W'((int'(last_grant) + k) % NUM_INGRESS);
            if (!pick_vld && req[rr_cand]) begin
                pick_vld = 1'b1;
                pick_idx = rr_cand;
            end
        end
    end

    // Next-state and output decode for the IDLE/BUSY/ABORT frame controller.
    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        owner_nxt       = owner;
        last_grant_nxt  = last_grant;
        stall_cnt_nxt   = stall_cnt;
        frame_count_nxt = frame_count;
        abort_nxt       = 1'b0;
        egress_source   = '0;
        for (int i = 0; i < NUM_INGRESS; i++) begin
            filter_sink[i].tready = 1'b0;
        end

        unique case (state)
            IDLE: begin
                // en only gates new grants; it never cuts a frame already granted.
                if (en && pick_vld) begin
                    grant_nxt     = {{(NUM_INGRESS-1){1'b0}}, 1'b1} << pick_idx;
                    owner_nxt     = pick_idx;
                    stall_cnt_nxt = '0;
                    state_nxt     = BUSY;
                end
            end

            BUSY: begin
                // tdest is ignored here: once granted, every beat up to tlast belongs to the frame.
                egress_source.tvalid       = own_vld;
                egress_source.tdata        = own_dat;
                egress_source.tlast        = own_last;
                filter_sink[owner].tready  = egress_sink.tready;

                if (beat_xfer) begin
                    stall_cnt_nxt = '0;
                    if (own_last) begin
                        frame_count_nxt = frame_count + 16'd1;
                        last_grant_nxt  = owner;
                        grant_nxt       = '0;
                        state_nxt       = IDLE;
                    end
                end else if (!own_vld) begin
                    // Only a silent source counts as a stall; egress backpressure just holds the count.
                    stall_cnt_nxt = stall_cnt + 1'b1;
                    if (stall_cnt == STALL_LIMIT - 1'b1) begin
                        state_nxt = ABORT;
                        abort_nxt = 1'b1;
                    end
                end
            end

            ABORT: begin
                // Emit one empty closing beat so the downstream frame is terminated cleanly.
                egress_source.tvalid = 1'b1;
                egress_source.tdata  = 16'h0000;
                egress_source.tlast  = 1'b1;
                if (egress_sink.tready) begin
                    frame_count_nxt = frame_count + 16'd1;
                    last_grant_nxt  = owner;
                    grant_nxt       = '0;
                    stall_cnt_nxt   = '0;
                    state_nxt       = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State registers; reset abandons any frame in flight without a closing beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            last_grant  <= IDX_W'(NUM_INGRESS - 1);
            stall_cnt   <= '0;
            frame_count <= '0;
            abort       <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            owner       <= owner_nxt;
            last_grant  <= last_grant_nxt;
            stall_cnt   <= stall_cnt_nxt;
            frame_count <= frame_count_nxt;
            abort       <= abort_nxt;
        end
    end

endmodule

// File: tb/tb_egress_arbiter.sv
// tb_egress_arbiter: directed scenarios plus a randomized multi-filter run against a frame-level round-robin model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Every wait is bounded by a cycle budget or the global time watchdog.

module tb_egress_arbiter;
    import egress_arbiter_pkg::*;

    localparam int         N   = 4;
    localparam logic [1:0] EID = 2'd0;
    localparam int         TW  = 3;

    typedef struct {
        int          f;
        logic [15:0] d;
        logic        l;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    axis_d_source_t fs [N];
    axis_d_sink_t   fk [N];
    axis_source_t   es;
    axis_sink_t     ek;
    logic [N-1:0]   grant;
    logic [15:0]    frame_count;
    logic           abort;

    int n_cmp = 0;
    int n_bad = 0;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    egress_arbiter #(
        .NUM_INGRESS       (N),
        .EGRESS_ID         (EID),
        .TIMEOUT_CTR_WIDTH (TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .filter_source (fs),
        .filter_sink   (fk),
        .egress_source (es),
        .egress_sink   (ek),
        .grant         (grant),
        .frame_count   (frame_count),
        .abort         (abort)
    );

    function automatic axis_d_source_t mk(logic v, logic [15:0] d, logic [1:0] t, logic l);
        axis_d_source_t s;
        s.tvalid = v;
        s.tdata  = d;
        s.tdest  = t;
        s.tlast  = l;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) fs[i] = mk(1'b0, 16'h0, 2'd0, 1'b0);
        en        = 1'b0;
        ek.tready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        en        = 1'b1;
        ek.tready = 1'b1;
        for (int i = 0; i < N; i++) fs[i] = mk(1'b1, 16'h1000 + 16'(i), EID, 1'b0);
        tick();
        tick();
        sample();
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL rst_grant got=%b exp=0000", grant); end
        n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL rst_frame_count got=%0d exp=0", frame_count); end
        n_cmp++; if (abort !== 1'b0) begin n_bad++; $display("FAIL rst_abort got=%b exp=0", abort); end
        n_cmp++; if (es !== '0) begin n_bad++; $display("FAIL rst_egress got=%h exp=0", es); end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (fk[i].tready !== 1'b0) begin n_bad++; $display("FAIL rst_tready[%0d] got=%b exp=0", i, fk[i].tready); end
        end
        idle_inputs();
    endtask

    task automatic test_single_frame();
        logic [15:0] d [4];
        do_reset();
        for (int k = 0; k < 4; k++) d[k] = 16'($urandom);
        en        = 1'b1;
        ek.tready = 1'b1;
        fs[0]     = mk(1'b1, d[0], EID, 1'b0);
        sample();
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL single_req_cycle_grant got=%b exp=0000", grant); end
        n_cmp++; if (es.tvalid !== 1'b0) begin n_bad++; $display("FAIL single_req_cycle_tvalid got=%b exp=0", es.tvalid); end
        for (int k = 0; k < 4; k++) begin
            tick();
            fs[0] = mk(1'b1, d[k], EID, (k == 3));
            sample();
            n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL single_grant beat%0d got=%b exp=0001", k, grant); end
            n_cmp++; if (es.tvalid !== 1'b1 || es.tdata !== d[k] || es.tlast !== (k == 3))
                begin n_bad++; $display("FAIL single_beat%0d got=%b/%h/%b exp=1/%h/%b", k, es.tvalid, es.tdata, es.tlast, d[k], (k == 3)); end
            n_cmp++; if (fk[0].tready !== 1'b1) begin n_bad++; $display("FAIL single_tready beat%0d got=%b exp=1", k, fk[0].tready); end
        end
        tick();
        fs[0] = mk(1'b0, 16'h0, EID, 1'b0);
        sample();
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL single_idle_grant got=%b exp=0000", grant); end
        n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL single_frame_count got=%0d exp=1", frame_count); end
    endtask

    task automatic test_round_robin();
        int           cnt [N];
        logic         xf [N];
        int           own;
        int           ph;
        logic [N-1:0] eg;
        do_reset();
        en        = 1'b1;
        ek.tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            fs[i]  = mk(1'b1, 16'(i * 256), EID, 1'b0);
        end
        for (int c = 0; c < 15; c++) begin
            sample();
            own = (c / 3) % N;
            ph  = c % 3;
            eg  = (ph == 0) ? '0 : (N'(1) << own);
            n_cmp++; if (grant !== eg) begin n_bad++; $display("FAIL rr_grant cyc%0d got=%b exp=%b", c, grant, eg); end
            for (int i = 0; i < N; i++) begin
                if (ph == 0 || i != own) begin
                    n_cmp++; if (fk[i].tready !== 1'b0) begin n_bad++; $display("FAIL rr_nonowner_tready cyc%0d f%0d got=%b exp=0", c, i, fk[i].tready); end
                end
            end
            if (ph != 0) begin
                n_cmp++; if (es.tdata !== fs[own].tdata || es.tlast !== (ph == 2))
                    begin n_bad++; $display("FAIL rr_data cyc%0d got=%h/%b exp=%h/%b", c, es.tdata, es.tlast, fs[own].tdata, (ph == 2)); end
            end
            for (int i = 0; i < N; i++) xf[i] = fs[i].tvalid && fk[i].tready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (xf[i]) begin
                    cnt[i]++;
                    fs[i] = mk(1'b1, 16'(i * 256 + cnt[i]), EID, (cnt[i] % 2 == 1));
                end
            end
        end
        sample();
        n_cmp++; if (frame_count !== 16'd5) begin n_bad++; $display("FAIL rr_frame_count got=%0d exp=5", frame_count); end
    endtask

    task automatic test_tdest_filter();
        logic [15:0] d0;
        logic [15:0] d1;
        do_reset();
        d0        = 16'($urandom);
        d1        = 16'($urandom);
        en        = 1'b1;
        ek.tready = 1'b1;
        fs[1]     = mk(1'b1, 16'hAAAA, 2'd2, 1'b1);
        fs[2]     = mk(1'b1, d0, EID, 1'b0);
        sample();
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL tdest_req_grant got=%b exp=0000", grant); end
        tick();
        sample();
        n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL tdest_grant got=%b exp=0100", grant); end
        n_cmp++; if (fk[1].tready !== 1'b0 || fk[2].tready !== 1'b1)
            begin n_bad++; $display("FAIL tdest_tready got f1=%b f2=%b exp f1=0 f2=1", fk[1].tready, fk[2].tready); end
        n_cmp++; if (es.tdata !== d0) begin n_bad++; $display("FAIL tdest_beat0 got=%h exp=%h", es.tdata, d0); end
        tick();
        // A later beat with a foreign tdest still belongs to the granted frame.
        fs[2] = mk(1'b1, d1, 2'd3, 1'b1);
        sample();
        n_cmp++; if (grant !== 4'b0100 || es.tdata !== d1 || es.tlast !== 1'b1)
            begin n_bad++; $display("FAIL tdest_beat1 got=%b/%h/%b exp=0100/%h/1", grant, es.tdata, es.tlast, d1); end
        tick();
        fs[2] = mk(1'b0, 16'h0, EID, 1'b0);
        for (int c = 0; c < 4; c++) begin
            sample();
            n_cmp++; if (grant !== 4'b0000 || fk[1].tready !== 1'b0)
                begin n_bad++; $display("FAIL tdest_mismatch_ungranted cyc%0d got grant=%b tready=%b exp 0000/0", c, grant, fk[1].tready); end
            tick();
        end
        sample();
        n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL tdest_frame_count got=%0d exp=1", frame_count); end
    endtask

    task automatic test_timeout();
        logic [15:0] d0;
        logic [15:0] d1;
        do_reset();
        d0        = 16'($urandom);
        d1        = 16'($urandom);
        en        = 1'b1;
        ek.tready = 1'b1;
        fs[0]     = mk(1'b1, d0, EID, 1'b0);
        fs[1]     = mk(1'b1, d1, EID, 1'b1);
        sample();
        tick();
        sample();
        n_cmp++; if (grant !== 4'b0001 || es.tdata !== d0) begin n_bad++; $display("FAIL to_first_beat got=%b/%h exp=0001/%h", grant, es.tdata, d0); end
        tick();
        fs[0].tvalid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            sample();
            n_cmp++; if (abort !== 1'b0 || grant !== 4'b0001 || es.tvalid !== 1'b0 || fk[1].tready !== 1'b0)
                begin n_bad++; $display("FAIL to_stall cyc%0d got abort=%b grant=%b tvalid=%b f1rdy=%b exp 0/0001/0/0", c, abort, grant, es.tvalid, fk[1].tready); end
            tick();
        end
        sample();
        n_cmp++; if (abort !== 1'b1) begin n_bad++; $display("FAIL to_abort_pulse got=%b exp=1", abort); end
        n_cmp++; if (es.tvalid !== 1'b1 || es.tdata !== 16'h0000 || es.tlast !== 1'b1)
            begin n_bad++; $display("FAIL to_abort_beat got=%b/%h/%b exp=1/0000/1", es.tvalid, es.tdata, es.tlast); end
        n_cmp++; if (grant !== 4'b0001 || fk[0].tready !== 1'b0 || fk[1].tready !== 1'b0)
            begin n_bad++; $display("FAIL to_abort_hold got grant=%b rdy0=%b rdy1=%b exp 0001/0/0", grant, fk[0].tready, fk[1].tready); end
        tick();
        sample();
        n_cmp++; if (abort !== 1'b0 || grant !== 4'b0000 || frame_count !== 16'd1)
            begin n_bad++; $display("FAIL to_after_abort got abort=%b grant=%b fc=%0d exp 0/0000/1", abort, grant, frame_count); end
        tick();
        sample();
        n_cmp++; if (grant !== 4'b0010 || es.tdata !== d1 || es.tlast !== 1'b1)
            begin n_bad++; $display("FAIL to_next_grant got=%b/%h exp=0010/%h", grant, es.tdata, d1); end
        tick();
        fs[1] = mk(1'b0, 16'h0, EID, 1'b0);
        sample();
        n_cmp++; if (frame_count !== 16'd2) begin n_bad++; $display("FAIL to_frame_count got=%0d exp=2", frame_count); end
    endtask

    task automatic test_gap_below_limit();
        logic [15:0] d0;
        logic [15:0] d1;
        do_reset();
        d0        = 16'($urandom);
        d1        = 16'($urandom);
        en        = 1'b1;
        ek.tready = 1'b1;
        fs[0]     = mk(1'b1, d0, EID, 1'b0);
        sample();
        tick();
        sample();
        tick();
        fs[0].tvalid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            sample();
            n_cmp++; if (abort !== 1'b0) begin n_bad++; $display("FAIL gap6_abort cyc%0d got=%b exp=0", c, abort); end
            tick();
        end
        fs[0] = mk(1'b1, d1, EID, 1'b1);
        sample();
        n_cmp++; if (grant !== 4'b0001 || es.tvalid !== 1'b1 || es.tdata !== d1 || es.tlast !== 1'b1)
            begin n_bad++; $display("FAIL gap6_last_beat got=%b/%b/%h/%b exp=0001/1/%h/1", grant, es.tvalid, es.tdata, es.tlast, d1); end
        tick();
        fs[0] = mk(1'b0, 16'h0, EID, 1'b0);
        sample();
        n_cmp++; if (grant !== 4'b0000 || frame_count !== 16'd1 || abort !== 1'b0 || es.tvalid !== 1'b0)
            begin n_bad++; $display("FAIL gap6_done got grant=%b fc=%0d abort=%b tvalid=%b exp 0000/1/0/0", grant, frame_count, abort, es.tvalid); end
    endtask

    task automatic test_backpressure();
        logic [15:0] d0;
        logic [15:0] d1;
        do_reset();
        d0        = 16'($urandom);
        d1        = 16'($urandom);
        en        = 1'b1;
        ek.tready = 1'b0;
        fs[0]     = mk(1'b1, d0, EID, 1'b0);
        sample();
        for (int c = 0; c < 20; c++) begin
            tick();
            sample();
            n_cmp++; if (grant !== 4'b0001 || es.tvalid !== 1'b1 || es.tdata !== d0 || abort !== 1'b0 || fk[0].tready !== 1'b0)
                begin n_bad++; $display("FAIL bp_hold cyc%0d got %b/%b/%h/%b/%b exp 0001/1/%h/0/0", c, grant, es.tvalid, es.tdata, abort, fk[0].tready, d0); end
        end
        tick();
        ek.tready = 1'b1;
        sample();
        n_cmp++; if (es.tdata !== d0 || fk[0].tready !== 1'b1) begin n_bad++; $display("FAIL bp_release got=%h/%b exp=%h/1", es.tdata, fk[0].tready, d0); end
        tick();
        fs[0] = mk(1'b1, d1, EID, 1'b1);
        sample();
        n_cmp++; if (es.tdata !== d1 || es.tlast !== 1'b1) begin n_bad++; $display("FAIL bp_beat1 got=%h/%b exp=%h/1", es.tdata, es.tlast, d1); end
        tick();
        fs[0] = mk(1'b0, 16'h0, EID, 1'b0);
        sample();
        n_cmp++; if (grant !== 4'b0000 || frame_count !== 16'd1 || abort !== 1'b0)
            begin n_bad++; $display("FAIL bp_done got grant=%b fc=%0d abort=%b exp 0000/1/0", grant, frame_count, abort); end
    endtask

    task automatic test_enable_and_reset();
        logic [15:0] d [4];
        do_reset();
        for (int k = 0; k < 4; k++) d[k] = 16'($urandom);
        ek.tready = 1'b1;
        fs[0]     = mk(1'b1, d[0], EID, 1'b0);
        for (int c = 0; c < 5; c++) begin
            sample();
            n_cmp++; if (grant !== 4'b0000 || fk[0].tready !== 1'b0) begin n_bad++; $display("FAIL en0_no_grant cyc%0d got=%b/%b exp=0000/0", c, grant, fk[0].tready); end
            tick();
        end
        en = 1'b1;
        sample();
        tick();
        sample();
        n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL en1_grant got=%b exp=0001", grant); end
        en = 1'b0;
        tick();
        fs[0] = mk(1'b1, d[1], EID, 1'b0);
        sample();
        n_cmp++; if (grant !== 4'b0001 || es.tdata !== d[1]) begin n_bad++; $display("FAIL en_drop_mid got=%b/%h exp=0001/%h", grant, es.tdata, d[1]); end
        tick();
        fs[0] = mk(1'b1, d[2], EID, 1'b1);
        sample();
        n_cmp++; if (grant !== 4'b0001 || es.tdata !== d[2] || es.tlast !== 1'b1)
            begin n_bad++; $display("FAIL en_drop_last got=%b/%h/%b exp=0001/%h/1", grant, es.tdata, es.tlast, d[2]); end
        tick();
        fs[0] = mk(1'b1, d[3], EID, 1'b0);
        for (int c = 0; c < 5; c++) begin
            sample();
            n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL en_drop_no_regrant cyc%0d got=%b exp=0000", c, grant); end
            tick();
        end
        sample();
        n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL en_frame_count got=%0d exp=1", frame_count); end
        en = 1'b1;
        tick();
        sample();
        n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL midrst_pre_grant got=%b exp=0001", grant); end
        reset = 1'b1;
        tick();
        sample();
        n_cmp++; if (grant !== 4'b0000 || frame_count !== 16'd0 || abort !== 1'b0 || es !== '0 || fk[0].tready !== 1'b0)
            begin n_bad++; $display("FAIL midrst_outputs got grant=%b fc=%0d abort=%b es=%h rdy=%b exp 0000/0/0/0/0", grant, frame_count, abort, es, fk[0].tready); end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_random();
        logic [18:0]  bq [N][32];
        int           blen [N];
        int           ptr [N];
        int           gap [N];
        int           rem [N];
        int           mptr [N];
        logic         match [N];
        logic         xf [N];
        logic [1:0]   dst;
        exp_t         exp_q[$];
        exp_t         e;
        int           total;
        int           last;
        int           c;
        int           nfr;
        int           flen;
        int           cyc;
        logic         found;
        logic         done_frame;
        logic [N-1:0] rv;
        logic [N-1:0] og;

        do_reset();
        en    = 1'b1;
        total = 0;
        for (int i = 0; i < N; i++) begin
            match[i] = (i == 0) || ($urandom_range(0, 3) != 0);
            blen[i]  = 0;
            ptr[i]   = 0;
            gap[i]   = 0;
            mptr[i]  = 0;
            nfr      = match[i] ? int'($urandom_range(1, 4)) : 1;
            rem[i]   = match[i] ? nfr : 0;
            total    = total + rem[i];
            for (int j = 0; j < nfr; j++) begin
                flen = int'($urandom_range(1, 5));
                for (int b = 0; b < flen; b++) begin
                    if (b == 0) dst = match[i] ? EID : (EID ^ 2'($urandom_range(1, 3)));
                    else        dst = 2'($urandom_range(0, 3));
                    bq[i][blen[i]] = {dst, (b == flen - 1), 16'($urandom)};
                    blen[i]++;
                end
            end
        end

        // Frame-order model: every filter with frames left is requesting at each arbitration point.
        last = N - 1;
        for (int n = 0; n < total; n++) begin
            found = 1'b0;
            c     = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && rem[(last + k) % N] > 0) begin
                    found = 1'b1;
                    c     = (last + k) % N;
                end
            end
            rem[c]--;
            last       = c;
            done_frame = 1'b0;
            while (!done_frame) begin
                e.f = c;
                e.d = bq[c][mptr[c]][15:0];
                e.l = bq[c][mptr[c]][16];
                exp_q.push_back(e);
                done_frame = e.l;
                mptr[c]++;
            end
        end

        cyc = 0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            for (int i = 0; i < N; i++) begin
                if (ptr[i] < blen[i] && gap[i] == 0)
                    fs[i] = mk(1'b1, bq[i][ptr[i]][15:0], bq[i][ptr[i]][18:17], bq[i][ptr[i]][16]);
                else
                    fs[i] = mk(1'b0, 16'h0, 2'd0, 1'b0);
            end
            ek.tready = ($urandom_range(0, 3) != 0);
            sample();
            og = N'(1) << exp_q[0].f;
            for (int i = 0; i < N; i++) begin
                rv[i] = fk[i].tready;
                xf[i] = fs[i].tvalid && fk[i].tready;
            end
            n_cmp++; if ((rv & ~og) !== '0) begin n_bad++; $display("FAIL rnd_nonowner_tready cyc%0d got=%b owner=%0d", cyc, rv, exp_q[0].f); end
            n_cmp++; if (grant !== '0 && grant !== og) begin n_bad++; $display("FAIL rnd_grant cyc%0d got=%b exp=0000 or %b", cyc, grant, og); end
            n_cmp++; if (abort !== 1'b0) begin n_bad++; $display("FAIL rnd_abort cyc%0d got=%b exp=0", cyc, abort); end
            if (es.tvalid === 1'b1 && ek.tready === 1'b1) begin
                e = exp_q.pop_front();
                n_cmp++; if (es.tdata !== e.d || es.tlast !== e.l)
                    begin n_bad++; $display("FAIL rnd_beat cyc%0d f%0d got=%h/%b exp=%h/%b", cyc, e.f, es.tdata, es.tlast, e.d, e.l); end
            end
            tick();
            for (int i = 0; i < N; i++) begin
                if (xf[i]) begin
                    gap[i] = bq[i][ptr[i]][16] ? 0 : int'($urandom_range(0, 2));
                    ptr[i]++;
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end
            end
            cyc++;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rnd_timeout beats_left=%0d exp=0", exp_q.size()); end
        sample();
        n_cmp++; if (frame_count !== 16'(total)) begin n_bad++; $display("FAIL rnd_frame_count got=%0d exp=%0d", frame_count, total); end
        idle_inputs();
    endtask

    // Scenario sequence and summary.
    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_frame();
        test_round_robin();
        test_tdest_filter();
        test_timeout();
        test_gap_below_limit();
        test_backpressure();
        test_enable_and_reset();
        for (int r = 0; r < 4; r++) test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case a scenario never returns.
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/egress_arbiter.md
# egress_arbiter

Frame-granular round-robin arbiter that shares one switch egress port among `NUM_INGRESS` `ingress_filter` instances. Each filter presents a tagged stream (`axis_d_source_t`, with `tdest`). The arbiter grants one filter whose head beat targets `EGRESS_ID`, holds that grant until `tlast`, and forwards the stream untagged (`axis_source_t`) to the egress port. A stall watchdog closes a frame whose source goes silent mid-frame, so the port cannot hang.

## Interface
Parameters:
- `NUM_INGRESS`, 4: number of requesting filters (2..8).
- `EGRESS_ID`, 2'd0: `tdest` value served by this instance.
- `TIMEOUT_CTR_WIDTH`, 3: stall counter width; the limit is 2^W-1 cycles.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high reset.
- `en`  in  1: allows new grants. It is sampled only in IDLE.
- `filter_source[NUM_INGRESS]`  in  axis_d_source_t: per-filter tvalid/tdata[15:0]/tdest[1:0]/tlast.
- `filter_sink[NUM_INGRESS]`  out  axis_d_sink_t: per-filter tready.
- `egress_source`  out  axis_source_t: tvalid/tdata[15:0]/tlast to the egress port.
- `egress_sink`  in  axis_sink_t: egress tready.
- `grant`  out  NUM_INGRESS: one-hot owner. It is zero when there is no owner.
- `frame_count`  out  16: count of completed frames. It wraps modulo 2^16.
- `abort`  out  1: one-cycle pulse when a frame is force-closed.

## Operation
- Request i = `filter_source[i].tvalid && filter_source[i].tdest == EGRESS_ID`.
- `tdest` is checked only at arbitration. Later beats of a granted frame are forwarded regardless of their `tdest`.
- Registered state: `state` (IDLE/BUSY/ABORT), `grant`, `last_grant` index, stall counter, `frame_count`, `abort`.
- IDLE:
  - All `filter_sink` tready = 0. `egress_source` = 0.
  - If `en` and any request exists, select the first requester scanning from `(last_grant+1) mod NUM_INGRESS`.
  - Register the one-hot `grant`, clear the stall counter, and go to BUSY.
- BUSY, owner g:
  - `egress_source` = `filter_source[g]` (tvalid, tdata, tlast), combinationally.
  - `filter_sink[g].tready` = `egress_sink.tready`. All other filters see tready = 0.
  - A beat transfers when egress tvalid && tready.
  - Transfer with tlast: `frame_count`+1, `last_grant` <= g, `grant` <= 0, go to IDLE.
  - Stall counter:
    - clears on any transfer;
    - increments on each cycle with `filter_source[g].tvalid` = 0;
    - holds when tvalid=1 and tready=0, because egress backpressure is not a stall.
  - When the counter reaches 2^W-1: go to ABORT, pulse `abort`, and keep `grant`.
- ABORT:
  - `egress_source` = {tvalid=1, tdata=16'h0000, tlast=1}. All filter tready = 0.
  - On `egress_sink.tready`: `frame_count`+1, `last_grant` <= g, `grant` <= 0, go to IDLE.
  - Any residual beats from g are arbitrated later as a new frame.
- Deasserting `en` during BUSY/ABORT does not cut the frame; the frame completes normally.
- Non-requesting filters and filters whose `tdest` does not match always see tready = 0.

## Timing
- Reset values:
  - `state`=IDLE, `grant`=0, `last_grant`=NUM_INGRESS-1 (so filter 0 has first priority), `frame_count`=0, `abort`=0, stall counter=0.
  - All tready=0. `egress_source`=0.
  - A reset mid-frame abandons the frame with no ABORT beat.
- Grant latency: a request sampled in IDLE at cycle t makes BUSY/`grant` visible at t+1. The first beat can transfer at t+1.
- Data path: zero-latency combinational mux. No buffering inside the arbiter.
- An L-beat frame with continuous valid and ready occupies L+1 cycles, including one IDLE bubble.
- Back-to-back frames from the same filter are possible only when no other filter requests.
- Timeout: after 2^W-1 consecutive invalid cycles, ABORT is entered the following cycle. `abort` is high for that first ABORT cycle only.
- Simultaneous events:
  - A tlast transfer on the cycle the counter would saturate counts as a transfer: the frame completes normally and there is no abort.
  - A single-beat frame (tvalid and tlast on the first BUSY cycle) completes in that cycle.

## Test plan
- Single requester, frame of 4 beats, tdest=EGRESS_ID, ready held high -> `grant`=0001 one cycle after the request, 4 beats out unchanged, `frame_count`=1, IDLE on cycle 6.
- Filters 0-3 all requesting 2-beat frames continuously -> grant order 0,1,2,3,0. Each frame takes 3 cycles. Non-owners see tready=0 throughout.
- Filter 1 with tdest=2'd2 and filter 2 with tdest=EGRESS_ID -> only filter 2 is granted. Filter 1 tready stays 0.
- Owner drops tvalid for 7 cycles mid-frame (W=3) -> `abort` pulses once, one beat {0x0000, tlast=1} is emitted, `frame_count`+1, next requester granted.
- Egress tready low for 20 cycles while the owner holds tvalid -> no abort, data held stable, and the frame completes once tready returns.
- `en`=0 with requests pending -> no grant is issued. `en` dropped mid-frame -> the frame finishes, then there are no further grants. Reset asserted mid-frame -> all outputs are at reset values on the next cycle.
